// File: rtl/ahb_sram_pkg.sv
// rtl/ahb_sram_pkg.sv - shared encodings, FSM states and lane helpers for the AHB-Lite SRAM slave
// Contents: htrans_e / hsize_e bus encodings, state_e controller states,
//           lane_mask() byte-enable decode, is_misaligned() error decode.
package ahb_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } state_e;

  // Byte lanes touched by a transfer; lane n is HWDATA[8n+7:8n].
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
    case (hsize)
      HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_mask = 4'b1111;
      default:    lane_mask = 4'b0000;
    endcase
  endfunction

  // Sizes above a word are folded in here so one decode covers every ERROR cause.
  function automatic logic is_misaligned(input logic [2:0] hsize, input logic [1:0] addr_lo);
    case (hsize)
      HSIZE_BYTE: is_misaligned = 1'b0;
      HSIZE_HALF: is_misaligned = addr_lo[0];
      HSIZE_WORD: is_misaligned = (addr_lo != 2'b00);
      default:    is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_if.sv
// rtl/ahb_sram_if.sv - AHB-Lite slave-side bus bundle for one SRAM bank
// Signals: hsel, haddr[31:0], htrans[1:0], hwrite, hsize[2:0], hwdata[31:0], hready (bus ready in),
//          hreadyout, hresp, hrdata[31:0] (slave responses).
// Modports: slave (the SRAM controller), master (the bus side driving a bank).
interface ahb_sram_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
    output hreadyout, hresp, hrdata
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hwdata,
    input  hready, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_array.sv
// rtl/ahb_sram_array.sv - 2**ADDR_WIDTH x 32 synchronous RAM, byte-enabled write port, registered read port
// Ports: clk_i; we_i/waddr_i/wbe_i/wdata_i write port; re_i/raddr_i read request; rdata_o registered data.
// Reads return the contents before a same-edge write; the controller forwards around that.
module ahb_sram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [3:0]            wbe_i,
  input  logic [31:0]           wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int n = 0; n < 4; n++) begin
        if (wbe_i[n]) mem_q[waddr_i][8*n +: 8] <= wdata_i[8*n +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_sram_ctrl.sv
// rtl/ahb_sram_ctrl.sv - AHB-Lite SRAM bank controller: wait states, ERROR response, lane writes, forwarding
// Ports: clk_i bus clock; hreset_i synchronous active-high reset; bus (ahb_sram_if.slave) AHB-Lite slave port.
// Parameters: ADDR_WIDTH word-index bits (bank aliases above them), WAIT_STATES extra OKAY data-phase cycles.
module ahb_sram_ctrl
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk_i,
  input  logic       hreset_i,
  ahb_sram_if.slave  bus
);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pv_q, pv_d;        // an OKAY transfer is in its data phase
  logic                  pw_q, pw_d;        // ... and it is a write
  logic [ADDR_WIDTH-1:0] pidx_q, pidx_d;
  logic [3:0]            pmask_q, pmask_d;
  logic                  zero_q, zero_d;    // HRDATA forced to zero (reset / error)
  logic [3:0]            fmask_q, fmask_d;  // lanes of HRDATA taken from forwarded write data
  logic [31:0]           fdata_q, fdata_d;

  logic                  xfer_req, accept, acc_err, acc_ok, commit, re, fwd;
  logic [ADDR_WIDTH-1:0] acc_idx, raddr;
  logic [31:0]           arr_rdata;
  logic                  unused_haddr;

  assign unused_haddr = ^bus.haddr[31:ADDR_WIDTH+2];

  assign xfer_req = (bus.htrans == HTRANS_NONSEQ) || (bus.htrans == HTRANS_SEQ);
  // Only IDLE and ERR2 end a data phase, so only they may take a new address.
  assign accept   = bus.hsel && bus.hready && xfer_req && (state_q == IDLE || state_q == ERR2);
  assign acc_err  = is_misaligned(bus.hsize, bus.haddr[1:0]);
  assign acc_ok   = accept && !acc_err;
  assign acc_idx  = bus.haddr[ADDR_WIDTH+1:2];

  // A pending write's data phase ends in IDLE; ERR2 never carries a pending write.
  assign commit = pv_q && pw_q && (state_q == IDLE) && !hreset_i;
  // Reads sample on the edge that starts their last data-phase cycle.
  assign re     = (acc_ok && !bus.hwrite && (WAIT_STATES == 0)) ||
                  ((state_q == WAIT) && (cnt_q == 4'd1) && !pw_q);
  assign raddr  = (state_q == WAIT) ? pidx_q : acc_idx;
  assign fwd    = commit && (pidx_q == raddr);

  ahb_sram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk_i   (clk_i),
    .we_i    (commit),
    .waddr_i (pidx_q),
    .wbe_i   (pmask_q),
    .wdata_i (bus.hwdata),
    .re_i    (re && !hreset_i),
    .raddr_i (raddr),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (hreset_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      pv_q    <= 1'b0;
      pw_q    <= 1'b0;
      pidx_q  <= '0;
      pmask_q <= 4'd0;
      zero_q  <= 1'b1;
      fmask_q <= 4'd0;
      fdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pv_q    <= pv_d;
      pw_q    <= pw_d;
      pidx_q  <= pidx_d;
      pmask_q <= pmask_d;
      zero_q  <= zero_d;
      fmask_q <= fmask_d;
      fdata_q <= fdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pv_d          = pv_q;
    pw_d          = pw_q;
    pidx_d        = pidx_q;
    pmask_d       = pmask_q;
    zero_d        = zero_q;
    fmask_d       = fmask_q;
    fdata_d       = fdata_q;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;

    case (state_q)
      IDLE, ERR2: begin
        pv_d    = acc_ok;
        state_d = IDLE;
        if (acc_ok) begin
          pw_d    = bus.hwrite;
          pidx_d  = acc_idx;
          pmask_d = lane_mask(bus.hsize, bus.haddr[1:0]);
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end else if (accept) begin
          state_d = ERR1;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ERR1:    state_d = ERR2;
      default: state_d = IDLE;
    endcase

    case (state_q)
      WAIT:    bus.hreadyout = 1'b0;
      ERR1:    begin bus.hreadyout = 1'b0; bus.hresp = 1'b1; end
      ERR2:    bus.hresp = 1'b1;
      default: ;
    endcase

    if (re) begin
      zero_d  = 1'b0;
      fmask_d = fwd ? pmask_q : 4'd0;
      fdata_d = bus.hwdata;
    end else if (accept && acc_err) begin
      zero_d  = 1'b1;
    end
  end

  always_comb begin
    bus.hrdata = 32'd0;
    for (int n = 0; n < 4; n++) begin
      if (!zero_q) bus.hrdata[8*n +: 8] = fmask_q[n] ? fdata_q[8*n +: 8] : arr_rdata[8*n +: 8];
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb/tb_ahb_sram_ctrl.sv - scoreboard bench for ahb_sram_ctrl (zero-wait bank and 3-wait 16-word bank)
module tb_ahb_sram_ctrl;

  logic        clk = 1'b0;
  logic        hreset;
  bit          dsel;
  int          ws_cur;
  logic        m_hsel, m_hwrite;
  logic [31:0] m_haddr, m_hwdata;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize;
  logic        m_hready, m_hresp;
  logic [31:0] m_hrdata;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit          resp;
    bit          chk;
    logic [31:0] data;
    int          waits;
  } exp_t;
  exp_t q[$];

  ahb_sram_if if0 ();
  ahb_sram_if if1 ();

  assign if0.hsel   = m_hsel && !dsel;
  assign if0.haddr  = m_haddr;
  assign if0.htrans = m_htrans;
  assign if0.hwrite = m_hwrite;
  assign if0.hsize  = m_hsize;
  assign if0.hwdata = m_hwdata;
  assign if0.hready = if0.hreadyout;
  assign if1.hsel   = m_hsel && dsel;
  assign if1.haddr  = m_haddr;
  assign if1.htrans = m_htrans;
  assign if1.hwrite = m_hwrite;
  assign if1.hsize  = m_hsize;
  assign if1.hwdata = m_hwdata;
  assign if1.hready = if1.hreadyout;

  assign m_hready = dsel ? if1.hreadyout : if0.hreadyout;
  assign m_hresp  = dsel ? if1.hresp     : if0.hresp;
  assign m_hrdata = dsel ? if1.hrdata    : if0.hrdata;

  ahb_sram_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (.clk_i(clk), .hreset_i(hreset), .bus(if0));
  ahb_sram_ctrl #(.ADDR_WIDTH(4),  .WAIT_STATES(3)) dut1 (.clk_i(clk), .hreset_i(hreset), .bus(if1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: tracks data phases on the selected bank and scores each against the queue.
  bit mon_act   = 1'b0;
  int mon_waits = 0;
  always @(negedge clk) begin
    exp_t e;
    if (hreset) begin
      if (mon_act && q.size() > 0) void'(q.pop_front());
      mon_act = 1'b0;
    end else begin
      if (mon_act) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL scoreboard_empty: data phase seen with no expected entry");
          mon_act = 1'b0;
        end else if (!m_hready) begin
          mon_waits++;
          check("wait_hresp", 32'(m_hresp), 32'(q[0].resp));
        end else begin
          e = q.pop_front();
          check("hresp", 32'(m_hresp), 32'(e.resp));
          check("wait_cycles", 32'(mon_waits), 32'(e.waits));
          if (e.chk) check("hrdata", m_hrdata, e.data);
          mon_act = 1'b0;
        end
      end
      if (m_hready && m_hsel && m_htrans[1]) begin
        mon_act   = 1'b1;
        mon_waits = 0;
      end
    end
  end

  task automatic step_ready();
    int n = 0;
    while (!m_hready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_hready) begin
      n_checks++;
      $display("FAIL ready_timeout: hreadyout still 0 after %0d cycles, expected 1", n);
    end
    @(posedge clk); #1;
  endtask

  task automatic push_exp(input bit w, input bit err, input logic [31:0] rexp);
    exp_t e;
    e.resp  = err;
    e.chk   = err || !w;
    e.data  = err ? 32'h0 : rexp;
    e.waits = err ? 1 : ws_cur;
    q.push_back(e);
  endtask

  task automatic xfer(input bit w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, input bit err, input logic [31:0] rexp);
    m_hsel = 1'b1; m_htrans = 2'b10; m_haddr = a; m_hwrite = w; m_hsize = sz;
    push_exp(w, err, rexp);
    step_ready();
    m_hwdata = wd;
  endtask

  task automatic idle_bus();
    m_hsel = 1'b0; m_htrans = 2'b00; m_haddr = 32'h0; m_hwrite = 1'b0; m_hsize = 3'd0;
    step_ready();
    m_hwdata = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    dsel = 1'b0; ws_cur = 0; hreset = 1'b1;
    m_hsel = 1'b0; m_htrans = 2'b00; m_haddr = 32'h0; m_hwrite = 1'b0; m_hsize = 3'd0; m_hwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 hreset = 1'b0;

    check("rst_hreadyout0", 32'(if0.hreadyout), 32'd1);
    check("rst_hresp0",     32'(if0.hresp),     32'd0);
    check("rst_hrdata0",    if0.hrdata,         32'd0);
    check("rst_hreadyout1", 32'(if1.hreadyout), 32'd1);
    check("rst_hresp1",     32'(if1.hresp),     32'd0);
    check("rst_hrdata1",    if1.hrdata,         32'd0);

    // Zero-wait bank: forwarding, lane writes, errors (second error taken in ERR2).
    xfer(1, 32'h10, 3'd2, 32'hDEADBEEF, 0, 32'h0);
    xfer(0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF);
    xfer(1, 32'h20, 3'd2, 32'h01020304, 0, 32'h0);
    xfer(1, 32'h21, 3'd0, 32'hEEEE11EE, 0, 32'h0);
    xfer(1, 32'h22, 3'd1, 32'hAABB5566, 0, 32'h0);
    xfer(0, 32'h20, 3'd2, 32'h0,        0, 32'hAABB1104);
    xfer(1, 32'h13, 3'd2, 32'h12345678, 1, 32'h0);
    xfer(0, 32'h10, 3'd3, 32'h0,        1, 32'h0);
    xfer(0, 32'h21, 3'd1, 32'h0,        1, 32'h0);
    xfer(0, 32'h10, 3'd2, 32'h0,        0, 32'hDEADBEEF);
    idle_bus();

    // Three-wait, 16-word bank: error length, commit timing, aliasing.
    dsel = 1'b1; ws_cur = 3;
    xfer(0, 32'h04, 3'd3, 32'h0,        1, 32'h0);
    xfer(1, 32'h04, 3'd2, 32'h00000055, 0, 32'h0);
    xfer(0, 32'h44, 3'd2, 32'h0,        0, 32'h00000055);
    xfer(0, 32'h04, 3'd2, 32'h0,        0, 32'h00000055);
    xfer(1, 32'h08, 3'd2, 32'h0BADF00D, 0, 32'h0);
    idle_bus();

    // Reset in the middle of a wait-state write.
    m_hsel = 1'b1; m_htrans = 2'b10; m_haddr = 32'h08; m_hwrite = 1'b1; m_hsize = 3'd2;
    push_exp(1, 0, 32'h0);
    step_ready();
    m_hwdata = 32'hCAFEBABE;
    m_hsel = 1'b0; m_htrans = 2'b00;
    @(posedge clk); #1;
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    check("midrst_hreadyout", 32'(m_hready), 32'd1);
    check("midrst_hresp",     32'(m_hresp),  32'd0);
    check("midrst_hrdata",    m_hrdata,      32'd0);
    xfer(0, 32'h08, 3'd2, 32'h0, 0, 32'h0BADF00D);
    idle_bus();

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
